// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command and response valid/ready channels of the ALU sequencer.
// The master drives commands and consumes responses; the slave is the sequencer.
interface alu_cmd_sequencer_if #(parameter int N = 4);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_error;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to a combinational ALU, captures results after SETTLE edges.
// Optional ALU_SEQ_OPCHECK_EN: opcodes above 9 are answered with an error and never issued.
module alu_cmd_sequencer #(
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic [3:0]           alu_opcode,
    input  logic [N-1:0]         alu_result,
    input  logic [3:0]           alu_flags,
    input  logic                 alu_div0,
    input  logic                 alu_mod0,
    output logic [CNT_W-1:0]     op_count,
    output logic [CNT_W-1:0]     err_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [N-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]         op_q, op_d, flg_q, flg_d;
    logic               err_q, err_d, vld_q, vld_d;
    logic [CNT_W-1:0]   opc_q, opc_d, errc_q, errc_d;
    logic               bad_op;

`ifdef ALU_SEQ_OPCHECK_EN
    assign bad_op = bus.cmd_opcode > 4'd9;
`else
    assign bad_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        err_d   = err_q;
        vld_d   = vld_q;
        opc_d   = opc_q;
        errc_d  = errc_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                if (bad_op) begin
                    res_d   = '0;
                    flg_d   = '0;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    op_d    = bus.cmd_opcode;
                    cnt_d   = 4'(SETTLE);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = alu_result;
                    flg_d   = alu_flags;
                    err_d   = alu_div0 | alu_mod0;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (bus.rsp_ready) begin
                vld_d   = 1'b0;
                opc_d   = &opc_q ? opc_q : opc_q + CNT_W'(1);
                errc_d  = (&errc_q || !err_q) ? errc_q : errc_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            opc_q   <= '0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            opc_q   <= opc_d;
            errc_q  <= errc_d;
        end
    end

    // Ready is forced low during reset even though the state already reads IDLE.
    assign bus.cmd_ready  = (state_q == IDLE) && !rst;
    assign bus.rsp_valid  = vld_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_flags  = flg_q;
    assign bus.rsp_error  = err_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_opcode     = op_q;
    assign op_count       = opc_q;
    assign err_count      = errc_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed plus random commands against a behavioural ALU and
// transaction-level expectations (latency, held outputs, saturating counters).
module tb_alu_cmd_sequencer;
    localparam int N      = 4;
    localparam int SETTLE = 3;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     alu_a, alu_b, alu_result, ar, glitch;
    logic [3:0]       alu_opcode, alu_flags;
    logic             alu_div0, alu_mod0;
    logic [CNT_W-1:0] op_count, err_count;

    int checks = 0, failures = 0;
    int exp_ops = 0, exp_errs = 0;
    logic [3:0] last_op = '0, last_a = '0, last_b = '0;

    alu_cmd_sequencer_if #(.N(N)) bus ();

    alu_cmd_sequencer #(.N(N), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .alu_div0(alu_div0), .alu_mod0(alu_mod0),
        .op_count(op_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {div0, mod0, N, Z, C, V, result}.
    function automatic logic [9:0] alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic c, v, d0, m0;
        s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0; d0 = 1'b0; m0 = 1'b0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'd2: r = 4'(a * b);
            4'd3: if (b == 0) d0 = 1'b1; else r = a / b;
            4'd4: if (b == 0) m0 = 1'b1; else r = a % b;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = ~a;
            4'd9: r = b;
            default: r = 4'd0;
        endcase
        return {d0, m0, r[3], r == 4'd0, c, v, r};
    endfunction

    assign {alu_div0, alu_mod0, alu_flags, ar} = alu(alu_opcode, alu_a, alu_b);
    assign alu_result = ar ^ glitch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int bp, input bit glitch_en);
        logic [9:0] r;
        bit skip;
        int t;
        t = 0;
        while (!bus.cmd_ready && t < 20) begin step(); t++; end
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        skip = 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
        skip = op > 4'd9;
`endif
        r = skip ? 10'b10_0000_0000 : alu(op, a, b);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b;
        step();
        // Keep a different command on the bus; it must not be taken before IDLE.
        bus.cmd_opcode = 4'($urandom_range(0, 15));
        bus.cmd_a = 4'($urandom); bus.cmd_b = 4'($urandom);
        if (!skip) begin
            for (int i = 0; i < SETTLE; i++) begin
                chk("wait_rsp_valid_low", bus.rsp_valid, 0);
                chk("wait_cmd_ready_low", bus.cmd_ready, 0);
                glitch = (glitch_en && i < SETTLE - 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                bus.rsp_ready = 1'($urandom_range(0, 1));
                step();
            end
            last_op = op; last_a = a; last_b = b;
        end
        glitch = 4'd0;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_rise", bus.rsp_valid, 1);
        chk("rsp_result", bus.rsp_result, r[3:0]);
        chk("rsp_flags", bus.rsp_flags, r[7:4]);
        chk("rsp_error", bus.rsp_error, r[9] | r[8]);
        chk("alu_opcode_issued", alu_opcode, last_op);
        for (int i = 0; i < bp; i++) begin
            step();
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_rsp_stable", {bus.rsp_result, bus.rsp_flags, bus.rsp_error}, {r[3:0], r[7:4], r[9] | r[8]});
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        exp_ops = (exp_ops < CMAX) ? exp_ops + 1 : CMAX;
        if (r[9] | r[8]) exp_errs = (exp_errs < CMAX) ? exp_errs + 1 : CMAX;
        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        chk("op_count", op_count, exp_ops);
        chk("err_count", err_count, exp_errs);
        chk("rsp_held", {bus.rsp_result, bus.rsp_flags, bus.rsp_error}, {r[3:0], r[7:4], r[9] | r[8]});
        chk("alu_held", {alu_opcode, alu_a, alu_b}, {last_op, last_a, last_b});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; glitch = 4'd0;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_opcode = 4'd0; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
        step(); step();
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_outputs", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_error, alu_a, alu_b, alu_opcode}, 0);
        chk("reset_counters", {op_count, err_count}, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", bus.cmd_ready, 1);

        do_op(4'd0, 4'd7, 4'd9, 0, 1'b0);
        chk("add_flags_0110", bus.rsp_flags, 4'b0110);
        do_op(4'd3, 4'd9, 4'd0, 0, 1'b0);
        chk("div0_err_count", err_count, 1);
        do_op(4'd1, 4'd3, 4'd5, 5, 1'b0);
        do_op(4'd2, 4'd3, 4'd3, 1, 1'b1);
        do_op(4'd12, 4'd1, 4'd2, 2, 1'b0);
        chk("op_count_saturated", op_count, CMAX);

        // Reset one cycle into WAIT: the pending result is dropped.
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 4'd0; bus.cmd_a = 4'd5; bus.cmd_b = 4'd6;
        step();
        bus.cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        chk("midrst_outputs", {bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.rsp_error, alu_a, alu_b, alu_opcode}, 0);
        chk("midrst_counters", {op_count, err_count}, 0);
        step();
        rst = 1'b0;
        exp_ops = 0; exp_errs = 0; last_op = '0; last_a = '0; last_b = '0;
        #1;
        chk("midrst_ready_after", bus.cmd_ready, 1);
        for (int i = 0; i < SETTLE + 2; i++) begin
            step();
            chk("midrst_no_rsp", bus.rsp_valid, 0);
        end

        for (int i = 0; i < 30; i++)
            do_op(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential initiator for the team's combinational 4-bit ALU. It accepts operation commands over a valid/ready interface and drives the ALU operand and opcode inputs from registers. After a settle interval it captures the ALU result, the N/Z/C/V flags and the divide/modulo-by-zero errors, then presents them downstream over a second valid/ready interface. It also keeps saturating counters of completed operations and errored operations for the lab board display.

Parameters:
N, 4, operand/result width; must match the attached ALU.
SETTLE, 1, clock edges between driving the ALU and capturing its outputs; legal range 1..15.
CNT_W, 8, width of op_count and err_count.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opcode  input  4  ALU opcode
cmd_a  input  N  operand a
cmd_b  input  N  operand b
alu_a  output  N  registered operand to ALU
alu_b  output  N  registered operand to ALU
alu_opcode  output  4  registered opcode to ALU
alu_result  input  N  ALU result
alu_flags  input  4  ALU {N,Z,C,V}
alu_div0  input  1  ALU divide-by-zero error
alu_mod0  input  1  ALU modulo-by-zero error
rsp_valid  output  1  response present
rsp_ready  input  1  downstream accepts response
rsp_result  output  N  captured result
rsp_flags  output  4  captured {N,Z,C,V}
rsp_error  output  1  captured alu_div0 | alu_mod0
op_count  output  CNT_W  completed responses, saturating
err_count  output  CNT_W  completed responses with rsp_error=1, saturating

Behaviour:
- One clock domain. Reset is asynchronous and active-high, on port rst; clock port is clk.
- Reset values: state IDLE; cmd_ready=0 while rst is high; alu_a, alu_b, alu_opcode, rsp_result, rsp_flags, rsp_error and rsp_valid all 0; both counters 0.
- FSM states:
  - IDLE: cmd_ready=1. On an edge with cmd_valid&cmd_ready: load alu_a/alu_b/alu_opcode from cmd_*, load settle counter with SETTLE, go to WAIT.
  - WAIT: cmd_ready=0. Decrement the counter each edge. On the edge where the counter is 1: capture alu_result/alu_flags/error into rsp_*, set rsp_valid=1, go to RESP.
  - RESP: rsp_valid=1. rsp_* are held stable until an edge with rsp_ready=1. On that edge: rsp_valid=0, op_count+1, err_count+1 if rsp_error, go to IDLE.
- Latency: for a command accepted at edge k, rsp_valid is high after edge k+SETTLE. Maximum throughput is one command per SETTLE+2 cycles, because cmd_ready is low in WAIT and RESP.
- cmd_ready depends only on state, never on cmd_valid. rsp_valid does not depend on rsp_ready.
- After a response, alu_a, alu_b and alu_opcode hold their last values until the next command. rsp_result, rsp_flags and rsp_error also hold their values while rsp_valid=0.
- Counters stop at all-ones and never wrap.
- Reset mid-operation, in WAIT or RESP: the pending result is discarded, all outputs return to reset values, and counters are cleared.
- rsp_ready high while in IDLE or WAIT has no effect.

Optional Feature:
ALU_SEQ_OPCHECK_EN
- Defined: an opcode above 4'b1001 is accepted but not issued. alu_* are left unchanged. The FSM goes from IDLE directly to RESP on the accept edge, with rsp_result=0, rsp_flags=0 and rsp_error=1. The response counts toward both counters.
- Undefined: every opcode is forwarded to the ALU and handled normally. An undefined opcode then returns the ALU default: result 0, Z=1, rsp_error=0.

Test Plan:
- Add, N=4, SETTLE=1: opcode 0000, a=7, b=9. ALU model returns result 0000, flags 0110 -> rsp_valid rises 1 edge after accept; rsp_result=0, rsp_flags=4'b0110, rsp_error=0; op_count=1.
- Divide by zero: opcode 0011, a=9, b=0 -> rsp_result=0, rsp_error=1; err_count=1, op_count=1.
- Backpressure: hold rsp_ready=0 for 5 cycles while cmd_valid stays high with a new command -> rsp_* stable and cmd_ready=0 throughout. Second command is accepted on the first edge after IDLE is re-entered.
- SETTLE=3: accept at edge k -> rsp_valid is first high after edge k+3; ALU outputs are sampled only at that edge. Glitches injected on alu_result at k+1 and k+2 are ignored.
- Mid-WAIT reset with SETTLE=3: assert rst one cycle after accept -> rsp_valid never rises, all outputs 0, counters 0, cmd_ready=1 once rst is released.
- Saturation and opcode check, CNT_W=2: complete 5 ops -> op_count=3. Opcode 1100 with ALU_SEQ_OPCHECK_EN -> response on the edge after accept with rsp_error=1 and alu_opcode unchanged. Without the macro -> forwarded to the ALU, rsp_error=0, rsp_flags Z=1.
